// File: rtl/nibble_add_sequencer.sv
// Multi-precision add/subtract sequencer: runs one 4-bit add-with-carry slice per
// clock over NIBBLES-wide operands, LSB nibble first, chaining the carry in a register.
module nibble_add_sequencer #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         carry_out,
    output logic         zero
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [W-1:0]     a_q,      a_d;
    logic [W-1:0]     b_q,      b_d;
    logic             sub_q,    sub_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic             cin_q,    cin_d;
    logic [W-1:0]     acc_q,    acc_d;
    logic [W-1:0]     result_q, result_d;
    logic             carry_q,  carry_d;
    logic             zero_q,   zero_d;

    logic [3:0]       a_sel;
    logic [3:0]       b_sel;
    logic [3:0]       b_eff;
    logic [3:0]       slice_s;
    logic             slice_c;
    logic [W-1:0]     acc_upd;

    // Nibble select for the current slice; idx never exceeds NIBBLES-1.
    always_comb begin
        a_sel = 4'h0;
        b_sel = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_sel = a_q[4*i +: 4];
                b_sel = b_q[4*i +: 4];
            end
        end
    end

    assign b_eff              = sub_q ? ~b_sel : b_sel;
    assign {slice_c, slice_s} = {1'b0, a_sel} + {1'b0, b_eff} + {4'h0, cin_q};

    // Accumulator with the current slice merged in; used both for the
    // per-cycle update and as the final result on the last slice.
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_acc
            assign acc_upd[4*gi +: 4] = (idx_q == IDX_W'(gi)) ? slice_s
                                                              : acc_q[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        idx_d    = idx_q;
        cin_d    = cin_q;
        acc_d    = acc_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    idx_d   = '0;
                    cin_d   = sub;
                    acc_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d = acc_upd;
                cin_d = slice_c;
                if (idx_q == LAST_IDX) begin
                    result_d = acc_upd;
                    carry_d  = slice_c;
                    zero_d   = (acc_upd == '0);
                    state_d  = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            idx_q    <= '0;
            cin_q    <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            idx_q    <= idx_d;
            cin_q    <= cin_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign carry_out = carry_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Bench for nibble_add_sequencer: a 4-nibble and a 1-nibble instance share stimulus and
// are checked every cycle against a transaction-level model, plus literal checks.
module tb_nibble_add_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        sub   = 1'b0;
    logic [15:0] a     = '0;
    logic [15:0] b     = '0;

    logic        busy4, done4, carry4, zero4;
    logic [15:0] result4;
    logic        busy1, done1, carry1, zero1;
    logic [3:0]  result1;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    nibble_add_sequencer #(.NIBBLES(4)) dut4 (
        .clock(clock), .reset(reset), .start(start), .sub(sub),
        .a(a), .b(b),
        .busy(busy4), .done(done4), .result(result4),
        .carry_out(carry4), .zero(zero4)
    );

    nibble_add_sequencer #(.NIBBLES(1)) dut1 (
        .clock(clock), .reset(reset), .start(start), .sub(sub),
        .a(a[3:0]), .b(b[3:0]),
        .busy(busy1), .done(done1), .result(result1),
        .carry_out(carry1), .zero(zero1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an operation accepted at edge t completes at edge t+N; done is
    // high in the following cycle, results move only on that completion.
    int          edge_cnt = 0;
    bit          model_valid = 0;
    bit          pend   [2];
    int          fin    [2];
    logic [15:0] op_res [2];
    logic        op_c   [2];
    logic        m_busy [2];
    logic        m_done [2];
    logic [15:0] m_res  [2];
    logic        m_c    [2];
    logic        m_z    [2];
    int          nn;
    int unsigned ra, rb, msk;
    bit          accept;

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            nn  = (k == 0) ? 4 : 1;
            msk = (32'd1 << (4 * nn)) - 1;
            if (reset) begin
                pend[k] = 0; m_busy[k] = 0; m_done[k] = 0;
                m_res[k] = '0; m_c[k] = 0; m_z[k] = 0;
            end else begin
                accept    = start && !pend[k];
                m_done[k] = 0;
                if (pend[k] && edge_cnt == fin[k]) begin
                    pend[k]   = 0;
                    m_done[k] = 1;
                    m_res[k]  = op_res[k];
                    m_c[k]    = op_c[k];
                    m_z[k]    = (op_res[k] == 0);
                end
                if (accept) begin
                    pend[k] = 1;
                    fin[k]  = edge_cnt + nn;
                    ra = {16'h0, a} & msk;
                    rb = {16'h0, b} & msk;
                    if (sub) begin
                        op_res[k] = 16'((ra - rb) & msk);
                        op_c[k]   = (ra >= rb);
                    end else begin
                        op_res[k] = 16'((ra + rb) & msk);
                        op_c[k]   = ((ra + rb) > msk);
                    end
                end
                m_busy[k] = pend[k];
            end
        end
        edge_cnt++;
        model_valid = 1;
    end

    always @(negedge clock) begin
        if (model_valid) begin
            chk("busy4",   {31'h0, busy4},  {31'h0, m_busy[0]});
            chk("done4",   {31'h0, done4},  {31'h0, m_done[0]});
            chk("result4", {16'h0, result4}, {16'h0, m_res[0]});
            chk("carry4",  {31'h0, carry4}, {31'h0, m_c[0]});
            chk("zero4",   {31'h0, zero4},  {31'h0, m_z[0]});
            chk("busy1",   {31'h0, busy1},  {31'h0, m_busy[1]});
            chk("done1",   {31'h0, done1},  {31'h0, m_done[1]});
            chk("result1", {28'h0, result1}, {16'h0, m_res[1]});
            chk("carry1",  {31'h0, carry1}, {31'h0, m_c[1]});
            chk("zero1",   {31'h0, zero1},  {31'h0, m_z[1]});
        end
    end

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=no_done required=done_within_bound", name);
    endtask

    // Returns at the negedge of the done4 cycle; counts busy4 cycles on the way.
    task automatic wait_done4(output int nbusy);
        nbusy = 0;
        for (int i = 0; i < 30; i++) begin
            if (done4) return;
            if (busy4) nbusy++;
            @(negedge clock);
        end
        timeout_fail("wait_done4");
    endtask

    task automatic op(input logic [15:0] ta, input logic [15:0] tb2, input logic ts,
                      output int nbusy);
        @(negedge clock);
        start = 1'b1; a = ta; b = tb2; sub = ts;
        @(negedge clock);
        start = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
        wait_done4(nbusy);
        $display("op a=%h b=%h sub=%0d -> r4=%h c4=%0d z4=%0d r1=%h c1=%0d busy4_cycles=%0d",
                 ta, tb2, ts, result4, carry4, zero4, result1, carry1, nbusy);
    endtask

    int nb, t1, t2, cnt;

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("reset_result4", {16'h0, result4}, 32'h0);
        chk("reset_busy4",   {31'h0, busy4},   32'h0);

        // single-nibble sums (and the 4-nibble view of the same operands)
        op(16'h000F, 16'h000F, 1'b0, nb);
        chk("t1_r1", {28'h0, result1}, 32'hE);
        chk("t1_c1", {31'h0, carry1},  32'h1);
        chk("t1_z1", {31'h0, zero1},   32'h0);
        chk("t1_r4", {16'h0, result4}, 32'h001E);
        op(16'h000E, 16'h0001, 1'b0, nb);
        chk("t1b_r1", {28'h0, result1}, 32'hF);
        chk("t1b_c1", {31'h0, carry1},  32'h0);

        op(16'h00FF, 16'h0001, 1'b0, nb);
        chk("t2_busy_cycles", nb, 32'd4);
        chk("t2_r4", {16'h0, result4}, 32'h0100);
        chk("t2_c4", {31'h0, carry4},  32'h0);
        op(16'hFFFF, 16'h0001, 1'b0, nb);
        chk("t2b_r4", {16'h0, result4}, 32'h0000);
        chk("t2b_c4", {31'h0, carry4},  32'h1);
        chk("t2b_z4", {31'h0, zero4},   32'h1);
        chk("t2b_r1", {28'h0, result1}, 32'h0);

        op(16'h0005, 16'h0007, 1'b1, nb);
        chk("t3a_r4", {16'h0, result4}, 32'hFFFE);
        chk("t3a_c4", {31'h0, carry4},  32'h0);
        op(16'h0007, 16'h0005, 1'b1, nb);
        chk("t3b_r4", {16'h0, result4}, 32'h0002);
        chk("t3b_c4", {31'h0, carry4},  32'h1);
        op(16'h1234, 16'h1234, 1'b1, nb);
        chk("t3c_r4", {16'h0, result4}, 32'h0);
        chk("t3c_z4", {31'h0, zero4},   32'h1);
        chk("t3c_c4", {31'h0, carry4},  32'h1);

        // start pulsed during RUN must be ignored by the 4-nibble instance
        @(negedge clock); start = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0;
        @(negedge clock); start = 1'b0;
        @(negedge clock); start = 1'b1; a = 16'hAAAA; b = 16'h5555;
        @(negedge clock); start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done4) cnt++;
            @(negedge clock);
        end
        $display("ignore_start: done4_pulses=%0d r4=%h", cnt, result4);
        chk("t4_done_count", cnt, 32'd1);
        chk("t4_r4", {16'h0, result4}, 32'h3333);

        // back-to-back with start held through the DONE cycle
        @(negedge clock); start = 1'b1; a = 16'h0001; b = 16'h0002; sub = 1'b0;
        @(negedge clock);
        wait_done4(nb);
        t1 = edge_cnt;
        chk("t5_r4_first", {16'h0, result4}, 32'h0003);
        a = 16'h1000; b = 16'h0FFF; sub = 1'b0;
        @(negedge clock); start = 1'b0;
        wait_done4(nb);
        t2 = edge_cnt;
        $display("back_to_back: done spacing=%0d r4=%h", t2 - t1, result4);
        chk("t5_spacing", t2 - t1, 32'd5);
        chk("t5_r4_second", {16'h0, result4}, 32'h1FFF);

        // reset during the second RUN cycle
        @(negedge clock); start = 1'b1; a = 16'h4321; b = 16'h1111; sub = 1'b0;
        @(negedge clock); start = 1'b0;
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        chk("t6_busy4",   {31'h0, busy4},   32'h0);
        chk("t6_done4",   {31'h0, done4},   32'h0);
        chk("t6_result4", {16'h0, result4}, 32'h0);
        chk("t6_carry4",  {31'h0, carry4},  32'h0);
        chk("t6_zero4",   {31'h0, zero4},   32'h0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done4) cnt++;
            @(negedge clock);
        end
        $display("reset_mid_op: stray done4 pulses=%0d", cnt);
        chk("t6_no_done", cnt, 32'd0);
        op(16'h4321, 16'h1111, 1'b0, nb);
        chk("t6_fresh_r4", {16'h0, result4}, 32'h5432);

        // randomized traffic, checked by the per-cycle model compare
        for (int i = 0; i < 1500; i++) begin
            @(negedge clock);
            reset = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 2) == 0);
            sub   = 1'($urandom);
            a     = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = 16'hFFFF;
                2:       b = 16'h0001;
                default: b = 16'($urandom);
            endcase
            if (start && !reset)
                $display("rand start a=%h b=%h sub=%0d", a, b, sub);
        end
        @(negedge clock); start = 1'b0; reset = 1'b0;
        repeat (8) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
